rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter.sv | 152 +++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: the pipeline (A) always wins, multi-cycle results (B) queue in a small FIFO.
// Optional statistics counters are compiled in with RF_WB_STATS_EN.
module rf_wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [4:0]  a_rd,
    input  logic [31:0] a_data,
    output logic        a_stall,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_rd,
    input  logic [31:0] b_data,
    output logic        RegWrite,
    output logic [4:0]  rc,
    output logic [31:0] dc,
    output logic [31:0] busy_mask
`ifdef RF_WB_STATS_EN
    ,
    output logic [15:0] b_write_cnt,
    output logic [15:0] stall_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [4:0]    r_fifo_rd   [DEPTH];
    logic [31:0]   r_fifo_data [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [SW-1:0] r_starve;
    logic          r_a_stall;
    logic          r_regwrite;
    logic [4:0]    r_rc;
    logic [31:0]   r_dc;
    logic          r_out_is_b;
    logic [31:0]   r_busy;

    logic          w_full;
    logic          w_empty;
    logic          w_b_ready;
    logic          w_enq;
    logic          w_sel_a;
    logic          w_sel_b;
    logic [31:0]   w_busy_set;
    logic [31:0]   w_busy_clr;
    logic [SW-1:0] w_starve_next;

    always_comb begin
        w_full     = (r_count == FULL_CNT);
        w_empty    = (r_count == '0);
        w_b_ready  = !w_full && !((b_rd != 5'd0) && r_busy[b_rd]);
        w_enq      = b_valid && w_b_ready && (b_rd != 5'd0);
        w_sel_a    = a_valid && (a_rd != 5'd0);
        w_sel_b    = !w_sel_a && !w_empty;
        w_busy_set = '0;
        if (w_enq)
            w_busy_set[b_rd] = 1'b1;
        // Busy bit drops once the register file has captured the B write.
        w_busy_clr = '0;
        if (r_regwrite && r_out_is_b)
            w_busy_clr[r_rc] = 1'b1;
        w_starve_next = '0;
        if (w_sel_a && !w_empty)
            w_starve_next = (r_starve == STARVE_MAX) ? r_starve : r_starve + SW'(1);
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_fifo_rd[r_wr_ptr]   <= b_rd;
            r_fifo_data[r_wr_ptr] <= b_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_starve   <= '0;
            r_a_stall  <= 1'b0;
            r_regwrite <= 1'b0;
            r_rc       <= '0;
            r_dc       <= '0;
            r_out_is_b <= 1'b0;
            r_busy     <= '0;
        end else begin
            if (w_enq)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_sel_b)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_enq && !w_sel_b)
                r_count <= r_count + CW'(1);
            else if (!w_enq && w_sel_b)
                r_count <= r_count - CW'(1);

            r_regwrite <= w_sel_a || w_sel_b;
            r_out_is_b <= w_sel_b;
            if (w_sel_a) begin
                r_rc <= a_rd;
                r_dc <= a_data;
            end else if (w_sel_b) begin
                r_rc <= r_fifo_rd[r_rd_ptr];
                r_dc <= r_fifo_data[r_rd_ptr];
            end

            r_busy   <= (r_busy & ~w_busy_clr) | w_busy_set;
            r_starve <= w_starve_next;
            // Stall holds (even if A ignores it) until B finally gets a slot.
            if (w_sel_b)
                r_a_stall <= 1'b0;
            else if (w_starve_next == STARVE_MAX)
                r_a_stall <= 1'b1;
        end
    end

`ifdef RF_WB_STATS_EN
    logic [15:0] r_b_write_cnt;
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_b_write_cnt <= '0;
            r_stall_cnt   <= '0;
        end else begin
            if (w_sel_b && (r_b_write_cnt != 16'hFFFF))
                r_b_write_cnt <= r_b_write_cnt + 16'd1;
            if (r_a_stall && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign b_write_cnt = r_b_write_cnt;
    assign stall_cnt   = r_stall_cnt;
`endif

    assign b_ready   = w_b_ready;
    assign a_stall   = r_a_stall;
    assign RegWrite  = r_regwrite;
    assign rc        = r_rc;
    assign dc        = r_dc;
    assign busy_mask = r_busy;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: queue-based reference model checked every cycle, plus directed literal checks.
module tb_rf_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0;
    logic [4:0]  a_rd = '0;
    logic [31:0] a_data = '0;
    logic        a_stall;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [4:0]  b_rd = '0;
    logic [31:0] b_data = '0;
    logic        RegWrite;
    logic [4:0]  rc;
    logic [31:0] dc;
    logic [31:0] busy_mask;
`ifdef RF_WB_STATS_EN
    logic [15:0] b_write_cnt;
    logic [15:0] stall_cnt;
`endif

    rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_stall(a_stall),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .RegWrite(RegWrite), .rc(rc), .dc(dc), .busy_mask(busy_mask)
`ifdef RF_WB_STATS_EN
        , .b_write_cnt(b_write_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending B results as a plain queue, busy registers as a set.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_busy = '0;
    logic        m_rw = 1'b0;
    logic [4:0]  m_rc = '0;
    logic [31:0] m_dc = '0;
    logic        m_out_b = 1'b0;
    int          m_starve = 0;
    logic        m_stall = 1'b0;

    function automatic logic model_b_ready();
        return (m_q.size() < DEPTH) && !((b_rd != 5'd0) && m_busy[b_rd]);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_busy = '0; m_rw = 1'b0; m_rc = '0; m_dc = '0;
            m_out_b = 1'b0; m_starve = 0; m_stall = 1'b0;
        end else begin
            int   n;
            logic acc, ga, gb;
            ent_t e;
            n   = m_q.size();
            acc = b_valid && model_b_ready();
            ga  = a_valid && (a_rd != 5'd0);
            gb  = !ga && (n > 0);
            if (m_rw && m_out_b) m_busy[m_rc] = 1'b0;
            m_out_b = gb;
            m_rw    = ga || gb;
            if (ga) begin
                m_rc = a_rd; m_dc = a_data;
            end else if (gb) begin
                e = m_q.pop_front();
                m_rc = e.rd; m_dc = e.data;
            end
            if (acc && b_rd != 5'd0) begin
                e.rd = b_rd; e.data = b_data;
                m_q.push_back(e);
                m_busy[b_rd] = 1'b1;
            end
            m_starve = (ga && n > 0) ? m_starve + 1 : 0;
            if (gb) m_stall = 1'b0;
            else if (m_starve >= LIMIT) m_stall = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("cyc_regwrite", 32'(RegWrite), 32'(m_rw));
            chk("cyc_rc", 32'(rc), 32'(m_rc));
            chk("cyc_dc", dc, m_dc);
            chk("cyc_busy", busy_mask, m_busy);
            chk("cyc_a_stall", 32'(a_stall), 32'(m_stall));
            chk("cyc_b_ready", 32'(b_ready), 32'(model_b_ready()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic v, input logic [4:0] rd, input logic [31:0] d);
        a_valid = v; a_rd = rd; a_data = d;
    endtask

    task automatic set_b(input logic v, input logic [4:0] rd, input logic [31:0] d);
        b_valid = v; b_rd = rd; b_data = d;
    endtask

    initial begin
        tick();
        chk("rst_regwrite", 32'(RegWrite), 32'h0);
        chk("rst_busy", busy_mask, 32'h0);
        chk("rst_stall", 32'(a_stall), 32'h0);
        chk("rst_rc", 32'(rc), 32'h0);
        tick();
        rst = 1'b0;
        #1 chk("rst_b_ready", 32'(b_ready), 32'h1);

        // A only
        set_a(1, 5'd8, 32'h1234);
        tick();
        chk("a_only_we", 32'(RegWrite), 32'h1);
        chk("a_only_rc", 32'(rc), 32'd8);
        chk("a_only_dc", dc, 32'h1234);
        chk("a_only_busy", busy_mask, 32'h0);
        set_a(0, 5'd0, 32'h0);
        tick();
        chk("a_idle_we", 32'(RegWrite), 32'h0);
        chk("a_idle_rc_hold", 32'(rc), 32'd8);

        // B only: write two cycles after accept, busy clears one cycle later
        set_b(1, 5'd9, 32'hCAFE);
        tick();
        set_b(0, 5'd0, 32'h0);
        chk("b_only_busy_set", busy_mask, 32'h0000_0200);
        chk("b_only_we0", 32'(RegWrite), 32'h0);
        tick();
        chk("b_only_we", 32'(RegWrite), 32'h1);
        chk("b_only_rc", 32'(rc), 32'd9);
        chk("b_only_dc", dc, 32'hCAFE);
        chk("b_only_busy_hold", busy_mask, 32'h0000_0200);
        tick();
        chk("b_only_busy_clr", busy_mask, 32'h0);

        // Full FIFO, backpressure, then starvation
        set_a(1, 5'd1, 32'h11);
        set_b(1, 5'd10, 32'h1010);
        tick();
        set_b(1, 5'd11, 32'h1111);
        tick();
        set_b(1, 5'd12, 32'h1212);
        #1 chk("full_b_ready", 32'(b_ready), 32'h0);
        chk("full_busy", busy_mask, 32'h0000_0C00);
        tick();
        set_b(1, 5'd10, 32'hDEAD);
        #1 chk("busy_b_ready", 32'(b_ready), 32'h0);
        tick();
        set_b(0, 5'd0, 32'h0);
        chk("starve_pre", 32'(a_stall), 32'h0);
        tick();
        chk("starve_set", 32'(a_stall), 32'h1);
        set_a(1, 5'd2, 32'hBEEF);
        tick();
        chk("viol_we", 32'(RegWrite), 32'h1);
        chk("viol_rc", 32'(rc), 32'd2);
        chk("viol_dc", dc, 32'hBEEF);
        chk("viol_stall", 32'(a_stall), 32'h1);
        set_a(0, 5'd0, 32'h0);
        tick();
        chk("starve_head_rc", 32'(rc), 32'd10);
        chk("starve_head_dc", dc, 32'h1010);
        chk("starve_clr", 32'(a_stall), 32'h0);
        tick();
        chk("drain_rc", 32'(rc), 32'd11);
        chk("drain_busy", busy_mask, 32'h0000_0800);
        tick();
        chk("drain_idle", 32'(RegWrite), 32'h0);
        chk("drain_busy0", busy_mask, 32'h0);

        // Zero register on both sides
        set_b(1, 5'd13, 32'h1313);
        tick();
        set_a(1, 5'd0, 32'h5555);
        set_b(1, 5'd0, 32'h7777);
        tick();
        chk("zero_head_we", 32'(RegWrite), 32'h1);
        chk("zero_head_rc", 32'(rc), 32'd13);
        chk("zero_head_dc", dc, 32'h1313);
        chk("zero_busy", busy_mask, 32'h0000_2000);
        set_a(0, 5'd0, 32'h0);
        set_b(0, 5'd0, 32'h0);
        tick();
        chk("zero_idle", 32'(RegWrite), 32'h0);
        chk("zero_busy0", busy_mask, 32'h0);

        // Reset with two queued entries
        set_a(1, 5'd3, 32'h33);
        set_b(1, 5'd20, 32'h2020);
        tick();
        set_b(1, 5'd21, 32'h2121);
        tick();
        set_b(0, 5'd0, 32'h0);
        chk("mid_busy", busy_mask, 32'h0030_0000);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_we", 32'(RegWrite), 32'h0);
        chk("mid_rst_busy", busy_mask, 32'h0);
        chk("mid_rst_rc", 32'(rc), 32'h0);
        set_a(0, 5'd0, 32'h0);
        tick();
        rst = 1'b0;
        #1 chk("post_rst_b_ready", 32'(b_ready), 32'h1);
        repeat (4) begin
            tick();
            chk("post_rst_no_write", 32'(RegWrite), 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
